carfield_regbus_guard_demux: RTL and testbench

- Single-outstanding RegBus demultiplexer in front of the carfield RegBus configuration targets: PCRs, PLL, padframe and L2 ECC.
- Decodes each upstream request against the carfield_configuration address map and forwards it to one target.
- Returns an error response for unmapped or disabled regions.
- Aborts any transaction whose target does not answer within a bounded number of cycles, so a hung peripheral cannot stall the host.

---
 rtl/carfield_regbus_guard_pkg.sv | 49 ++++
 rtl/carfield_regbus_addr_decode.sv | 28 ++
 rtl/carfield_regbus_guard_demux.sv | 158 +++++++++++++++
 tb/tb_carfield_regbus_guard_demux.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_regbus_guard_pkg.sv
// Shared types and the carfield RegBus configuration address map for the
// guarded RegBus demultiplexer.
package carfield_regbus_guard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned NumRules      = 4;
    localparam int unsigned IdxWidth      = 2;
    localparam int unsigned RuleAddrWidth = 48;

    localparam int unsigned PcrsIdx     = 0;
    localparam int unsigned PllIdx      = 1;
    localparam int unsigned PadframeIdx = 2;
    localparam int unsigned L2EccIdx    = 3;

    // carfield_configuration base addresses and sizes of the RegBus targets
    localparam logic [RuleAddrWidth-1:0] CarfieldPcrsBase     = 48'h0000_2001_0000;
    localparam logic [RuleAddrWidth-1:0] CarfieldPcrsSize     = 48'h0000_0000_1000;
    localparam logic [RuleAddrWidth-1:0] CarfieldPllBase      = 48'h0000_2002_0000;
    localparam logic [RuleAddrWidth-1:0] CarfieldPllSize      = 48'h0000_0000_1000;
    localparam logic [RuleAddrWidth-1:0] CarfieldPadframeBase = 48'h0000_200A_0000;
    localparam logic [RuleAddrWidth-1:0] CarfieldPadframeSize = 48'h0000_0000_1000;
    localparam logic [RuleAddrWidth-1:0] CarfieldL2EccBase    = 48'h0000_200B_0000;
    localparam logic [RuleAddrWidth-1:0] CarfieldL2EccSize    = 48'h0000_0000_1000;

    typedef struct packed {
        logic                     enable;
        logic [RuleAddrWidth-1:0] base;
        logic [RuleAddrWidth-1:0] size;
    } rule_t;

    typedef rule_t [NumRules-1:0] rule_map_t;

    function automatic rule_map_t gen_rule_map();
        rule_map_t m;
        m[PcrsIdx]     = '{enable: 1'b1, base: CarfieldPcrsBase,     size: CarfieldPcrsSize};
        m[PllIdx]      = '{enable: 1'b1, base: CarfieldPllBase,      size: CarfieldPllSize};
        m[PadframeIdx] = '{enable: 1'b1, base: CarfieldPadframeBase, size: CarfieldPadframeSize};
        m[L2EccIdx]    = '{enable: 1'b1, base: CarfieldL2EccBase,    size: CarfieldL2EccSize};
        return m;
    endfunction

    localparam rule_map_t RuleMap = gen_rule_map();

endpackage

// File: rtl/carfield_regbus_addr_decode.sv
// Combinational address decoder: matches an address against the rule map and
// returns the index of the enabled region containing it. Regions never
// overlap, so at most one rule can match.
module carfield_regbus_addr_decode
    import carfield_regbus_guard_pkg::*;
(
    input  rule_map_t                rules,
    input  logic [RuleAddrWidth-1:0] addr,
    output logic                     hit,
    output logic [IdxWidth-1:0]      idx
);

    // Base <= addr < Base+Size, with one extra bit so the upper limit cannot wrap
    always_comb begin
        logic [RuleAddrWidth:0] limit;
        hit   = 1'b0;
        idx   = '0;
        limit = '0;
        for (int k = 0; k < NumRules; k++) begin
            limit = {1'b0, rules[k].base} + {1'b0, rules[k].size};
            if (rules[k].enable && (addr >= rules[k].base) && ({1'b0, addr} < limit)) begin
                hit = 1'b1;
                idx = k[IdxWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/carfield_regbus_guard_demux.sv
// Single-outstanding RegBus demultiplexer with decode-error responses and a
// per-transaction timeout guard in front of the carfield configuration targets.
// Optional error statistics counter enabled by CARFIELD_REGBUS_GUARD_STATS_EN.
//
// state | meaning
// IDLE  | waiting for an upstream request
// FWD   | request presented to the selected target, timeout counter running
// RESP  | response registered; in_ready_o pulses once, then back to IDLE
module carfield_regbus_guard_demux
    import carfield_regbus_guard_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumSlv        = NumRules,
    parameter int unsigned          TimeoutCycles = 255,
    parameter logic [DataWidth-1:0] ErrData       = DataWidth'(32'hBADCAB1E)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    input  logic                          in_write_i,
    input  logic [AddrWidth-1:0]          in_addr_i,
    input  logic [DataWidth-1:0]          in_wdata_i,
    input  logic [DataWidth/8-1:0]        in_wstrb_i,
    output logic                          in_ready_o,
    output logic [DataWidth-1:0]          in_rdata_o,
    output logic                          in_error_o,
    output logic [NumSlv-1:0]             out_valid_o,
    output logic                          out_write_o,
    output logic [AddrWidth-1:0]          out_addr_o,
    output logic [DataWidth-1:0]          out_wdata_o,
    output logic [DataWidth/8-1:0]        out_wstrb_o,
    input  logic [NumSlv-1:0]             out_ready_i,
    input  logic [NumSlv*DataWidth-1:0]   out_rdata_i,
    input  logic [NumSlv-1:0]             out_error_i,
    output logic                          timeout_o
`ifdef CARFIELD_REGBUS_GUARD_STATS_EN
    ,
    output logic [15:0]                   err_cnt_o
`endif
);

    localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

    state_e                state;
    logic [15:0]           cnt;
    logic [IdxWidth-1:0]   idx_q;
    logic                  dec_hit;
    logic [IdxWidth-1:0]   dec_idx;
    logic                  fwd_ready;
    logic                  fwd_expire;
    logic [DataWidth-1:0]  rdata_arr [NumSlv];

    for (genvar g = 0; g < NumSlv; g++) begin : gen_rdata_slice
        assign rdata_arr[g] = out_rdata_i[g*DataWidth +: DataWidth];
    end

    carfield_regbus_addr_decode i_addr_decode (
        .rules (RuleMap),
        .addr  (RuleAddrWidth'(in_addr_i)),
        .hit   (dec_hit),
        .idx   (dec_idx)
    );

    // A target ready always beats an expiring counter in the same cycle
    assign fwd_ready  = out_ready_i[idx_q];
    assign fwd_expire = !fwd_ready && (cnt == CntLast);

    // Request sequencing: decode, forward with timeout guard, single response pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx_q       <= '0;
            in_ready_o  <= 1'b0;
            in_rdata_o  <= '0;
            in_error_o  <= 1'b0;
            out_valid_o <= '0;
            out_write_o <= 1'b0;
            out_addr_o  <= '0;
            out_wdata_o <= '0;
            out_wstrb_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            in_ready_o <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        out_write_o <= in_write_i;
                        out_addr_o  <= in_addr_i;
                        out_wdata_o <= in_wdata_i;
                        out_wstrb_o <= in_wstrb_i;
                        idx_q       <= dec_idx;
                        cnt         <= '0;
                        if (dec_hit) begin
                            out_valid_o <= NumSlv'(1) << dec_idx;
                            state       <= FWD;
                        end else begin
                            in_rdata_o <= ErrData;
                            in_error_o <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                FWD: begin
                    if (fwd_ready) begin
                        in_rdata_o  <= rdata_arr[idx_q];
                        in_error_o  <= out_error_i[idx_q];
                        in_ready_o  <= 1'b1;
                        out_valid_o <= '0;
                        cnt         <= '0;
                        state       <= RESP;
                    end else if (fwd_expire) begin
                        in_rdata_o  <= ErrData;
                        in_error_o  <= 1'b1;
                        in_ready_o  <= 1'b1;
                        timeout_o   <= 1'b1;
                        out_valid_o <= '0;
                        cnt         <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    // Decode errors arrive here without a pulse armed; give them one extra cycle
                    if (in_ready_o) begin
                        state <= IDLE;
                    end else begin
                        in_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= '0;
                end
            endcase
        end
    end

`ifdef CARFIELD_REGBUS_GUARD_STATS_EN
    logic local_err;

    assign local_err = ((state == IDLE) && in_valid_i && !dec_hit) ||
                       ((state == FWD) && fwd_expire);

    // Saturating count of locally generated errors (decode misses and timeouts)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (local_err && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_carfield_regbus_guard_demux.sv
// Scoreboard bench for carfield_regbus_guard_demux: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_carfield_regbus_guard_demux;

    localparam int          T     = 8;
    localparam int          NEVER = 1000;
    localparam logic [31:0] ERR   = 32'hBADCAB1E;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_write = 1'b0;
    logic [47:0]  in_addr = '0;
    logic [31:0]  in_wdata = '0;
    logic [3:0]   in_wstrb = '0;
    logic         in_ready;
    logic [31:0]  in_rdata;
    logic         in_error;
    logic [3:0]   out_valid;
    logic         out_write;
    logic [47:0]  out_addr;
    logic [31:0]  out_wdata;
    logic [3:0]   out_wstrb;
    logic [3:0]   out_ready = '0;
    logic [127:0] out_rdata = '0;
    logic [3:0]   out_error = '0;
    logic         timeout;
`ifdef CARFIELD_REGBUS_GUARD_STATS_EN
    logic [15:0]  err_cnt;
`endif

    carfield_regbus_guard_demux #(.TimeoutCycles(T)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_write_i  (in_write),
        .in_addr_i   (in_addr),
        .in_wdata_i  (in_wdata),
        .in_wstrb_i  (in_wstrb),
        .in_ready_o  (in_ready),
        .in_rdata_o  (in_rdata),
        .in_error_o  (in_error),
        .out_valid_o (out_valid),
        .out_write_o (out_write),
        .out_addr_o  (out_addr),
        .out_wdata_o (out_wdata),
        .out_wstrb_o (out_wstrb),
        .out_ready_i (out_ready),
        .out_rdata_i (out_rdata),
        .out_error_i (out_error),
        .timeout_o   (timeout)
`ifdef CARFIELD_REGBUS_GUARD_STATS_EN
        ,
        .err_cnt_o   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      cyc;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     exp_errcnt = 0;

    // reference address map, straight from the configuration table
    logic [47:0] rbase [4] = '{48'h2001_0000, 48'h2002_0000, 48'h200A_0000, 48'h200B_0000};

    // forward window expectation
    longint      win_lo = 1, win_hi = 0;
    logic [3:0]  win_mask = '0;
    logic        cur_write;
    logic [47:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;

    // target behaviour plan
    int          tgt_idx = -1;
    int          tgt_delay = 0;
    int          tgt_cnt = 0;
    logic [31:0] tgt_rdata = '0;
    logic        tgt_err = 1'b0;
    logic        stray_pcrs = 1'b0;

    always @(posedge clk) cyc++;

    function automatic int ref_decode(logic [47:0] a);
        for (int k = 0; k < 4; k++)
            if (a >= rbase[k] && a < rbase[k] + 48'h1000) return k;
        return -1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Target model: selected target answers after tgt_delay cycles; others emit noise
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = 4'($urandom);
            out_rdata = {$urandom, $urandom, $urandom, $urandom};
            out_error = 4'($urandom);
            if (tgt_idx >= 0) begin
                out_ready[tgt_idx] = 1'b0;
                if (out_valid[tgt_idx]) begin
                    if (tgt_cnt == tgt_delay) begin
                        out_ready[tgt_idx]          = 1'b1;
                        out_rdata[tgt_idx*32 +: 32] = tgt_rdata;
                        out_error[tgt_idx]          = tgt_err;
                    end
                    tgt_cnt++;
                end
            end
            if (stray_pcrs) out_ready[0] = 1'b1;
        end
    end

    // Monitor: forward-side window checks and scoreboard pop on every response
    always @(negedge clk) begin
        logic [3:0] exp_ov;
        exp_t e;
        exp_ov = (cyc >= win_lo && cyc <= win_hi) ? win_mask : 4'b0;
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov != 0) begin
            chk("out_fields", {out_write, out_wstrb, out_addr},
                {cur_write, cur_wstrb, cur_addr});
            chk("out_wdata", 64'(out_wdata), 64'(cur_wdata));
        end
        if (in_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(in_ready), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_rdata", 64'(in_rdata), 64'(e.rdata));
                chk("resp_error", 64'(in_error), 64'(e.err));
                chk("resp_timeout", 64'(timeout), 64'(e.tmo));
            end
        end else if (timeout) begin
            chk("stray_timeout", 64'(timeout), 64'(0));
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("response_wait_expired", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    task automatic start_req(input logic [47:0] a, input logic wr, input logic [31:0] wd,
                             input logic [3:0] ws, output longint n, output int k);
        @(posedge clk);
        #1;
        n        = cyc;
        k        = ref_decode(a);
        win_lo   = 1;
        win_hi   = 0;
        in_valid = 1'b1;
        in_write = wr;
        in_addr  = a;
        in_wdata = wd;
        in_wstrb = ws;
        cur_write = wr;
        cur_addr  = a;
        cur_wdata = wd;
        cur_wstrb = ws;
    endtask

    task automatic end_req();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_write = 1'($urandom);
        in_addr  = {16'($urandom), $urandom};
        in_wdata = $urandom;
        in_wstrb = 4'($urandom);
    endtask

    task automatic txn(input logic [47:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input int delay, input logic [31:0] rd,
                       input logic terr);
        longint n;
        int     k;
        start_req(a, wr, wd, ws, n, k);
        if (k < 0) begin
            tgt_idx = -1;
            sb.push_back('{n + 2, ERR, 1'b1, 1'b0});
            exp_errcnt++;
        end else begin
            tgt_idx   = k;
            tgt_cnt   = 0;
            tgt_delay = delay;
            tgt_rdata = rd;
            tgt_err   = terr;
            win_mask  = 4'(1 << k);
            win_lo    = n + 1;
            if (delay < T) begin
                win_hi = n + 1 + delay;
                sb.push_back('{n + 2 + delay, rd, terr, 1'b0});
            end else begin
                win_hi = n + T;
                sb.push_back('{n + T + 1, ERR, 1'b1, 1'b1});
                exp_errcnt++;
            end
        end
        end_req();
        wait_drain();
        tgt_idx = -1;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic reset_in_fwd(input logic [47:0] a);
        longint n;
        int     k;
        start_req(a, 1'b0, 32'h0, 4'hF, n, k);
        tgt_idx   = k;
        tgt_cnt   = 0;
        tgt_delay = NEVER;
        win_mask  = 4'(1 << k);
        win_lo    = n + 1;
        win_hi    = n + 3;
        end_req();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_errcnt = 0;
        tgt_idx    = -1;
        repeat (T + 4) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", 64'(in_ready), 64'(0));
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_timeout", 64'(timeout), 64'(0));
        chk("reset_resp", {in_error, in_rdata}, 64'(0));
`ifdef CARFIELD_REGBUS_GUARD_STATS_EN
        chk("reset_errcnt", 64'(err_cnt), 64'(0));
`endif

        txn(48'h2002_0004, 1'b0, $urandom, 4'hF, 3, 32'h0000_00A5, 1'b0);
        txn(48'h200B_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, $urandom, 1'b1);
        txn(48'h2003_0000, 1'b0, $urandom, 4'h0, 0, 32'h0, 1'b0);
        txn(48'h2001_0000, 1'b0, $urandom, 4'hF, NEVER, 32'h0, 1'b0);
        // a late PCRs ready after the abort must not produce a response
        @(posedge clk);
        #1;
        stray_pcrs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stray_pcrs = 1'b0;
        repeat (3) @(posedge clk);

        // ready on the last allowed cycle wins, one cycle later times out
        txn(48'h200A_0020, 1'b1, $urandom, 4'h5, T - 1, 32'h1234_5678, 1'b0);
        txn(48'h2002_0FFC, 1'b0, $urandom, 4'hF, T, 32'h0, 1'b0);

        // region edges
        txn(48'h2001_0FFF, 1'b0, $urandom, 4'hF, 1, 32'hCAFE_0001, 1'b0);
        txn(48'h2001_1000, 1'b0, $urandom, 4'hF, 0, 32'h0, 1'b0);
        txn(48'h200A_FFFF, 1'b0, $urandom, 4'hF, 0, 32'h0, 1'b0);
        txn(48'h200B_0000, 1'b1, $urandom, 4'hC, 2, 32'hCAFE_0002, 1'b0);

        reset_in_fwd(48'h2002_0040);
        txn(48'h200A_0000, 1'b0, $urandom, 4'hF, 2, 32'h5A5A_A5A5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [47:0] a;
            int          sel;
            sel = $urandom_range(0, 5);
            if (sel < 4) a = rbase[sel] + 48'($urandom_range(0, 32'hFFF));
            else if (sel == 4) a = 48'h2000_0000 + 48'($urandom_range(0, 32'hFF_FFFF));
            else a = {16'($urandom), $urandom};
            txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, T + 2),
                $urandom, 1'($urandom));
        end

`ifdef CARFIELD_REGBUS_GUARD_STATS_EN
        chk("err_cnt", 64'(err_cnt), 64'(exp_errcnt));
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
